// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the load/store unit.
//   - funct3 size/sign op codes (OP_B, OP_H, OP_W, OP_BU, OP_HU)
//   - data width and byte-lane constants
//   - LSU FSM state encoding
//   - request error decode helper
package risc_pkg;

    localparam int DW_C      = 32;
    localparam int LANES_C   = DW_C / 8;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // A request is rejected when its op is undefined, when a store asks for
    // an unsigned size (meaningless for stores), or when the access does not
    // sit on its natural alignment.
    function automatic logic lsu_req_err(input logic we, input logic [2:0] op,
                                         input logic [1:0] off);
        logic err;
        case (op)
            OP_B:    err = 1'b0;
            OP_H:    err = off[0];
            OP_W:    err = (off != 2'b00);
            OP_BU:   err = we;
            OP_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Ports:
//   word_i       - word read from data memory
//   wdata_i      - right-justified store data
//   off_i        - byte offset within the word (addr[1:0])
//   op_i         - funct3 size/sign op
//   load_val_o   - addressed lane(s) extracted and sign/zero extended
//   store_word_o - word_i with addressed lane(s) replaced by wdata_i
//                  (whole wdata_i for word ops)
module lsu_align
    import risc_pkg::*;
(
    input  logic [DW_C-1:0] word_i,
    input  logic [DW_C-1:0] wdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      op_i,
    output logic [DW_C-1:0] load_val_o,
    output logic [DW_C-1:0] store_word_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word_i[8*off_i +: 8];
        // Halfword ops are only legal with off_i[0] = 0, so off_i[1] picks the half.
        sel_half = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (op_i)
            OP_B:    load_val_o = {{24{sel_byte[7]}}, sel_byte};
            OP_BU:   load_val_o = {24'h0, sel_byte};
            OP_H:    load_val_o = {{16{sel_half[15]}}, sel_half};
            OP_HU:   load_val_o = {16'h0, sel_half};
            default: load_val_o = word_i;
        endcase
    end

    always_comb begin
        store_word_o = word_i;
        case (op_i)
            OP_B: store_word_o[8*off_i +: 8] = wdata_i[7:0];
            OP_H: begin
                if (off_i[1]) store_word_o[31:16] = wdata_i[15:0];
                else          store_word_o[15:0]  = wdata_i[15:0];
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit in front of the word-wide data memory dm.
// Takes one request at a time, turns byte address + size into a word access,
// runs sub-word stores as read-modify-write and returns extended load data.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/req_ready    - request handshake
//   req_we/op/addr/wdata   - request fields
//   rsp_valid/rdata/err    - one-cycle completion pulse with result
//   dm_add/dm_data_in/dm_wen/dm_data_out - data memory port
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE; req_valid outside IDLE
// is ignored. rsp_valid is a single-cycle pulse with no backpressure, and
// rsp_rdata/rsp_err are meaningful only while it is high (0 otherwise).
module lsu
    import risc_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [31:0]   dm_add,
    output logic [31:0]   dm_data_in,
    output logic          dm_wen,
    input  logic [31:0]   dm_data_out
);

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [2:0]    op_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] merge_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic [DW-1:0] load_val;
    logic [DW-1:0] store_word;

    assign accept  = req_valid & (state_q == ST_IDLE);
    assign req_err = lsu_req_err(req_we, req_op, req_addr[1:0]);

    lsu_align u_align (
        .word_i       (dm_data_out),
        .wdata_i      (wdata_q),
        .off_i        (addr_q[1:0]),
        .op_i         (op_q),
        .load_val_o   (load_val),
        .store_word_o (store_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)             state_d = ST_RESP;
                    else if (!req_we)        state_d = ST_LOAD;
                    else if (req_op == OP_W) state_d = ST_WRITE;
                    else                     state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs, all decoded from registered state so dm_wen cannot glitch.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        dm_wen    = (state_q == ST_WRITE);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid & err_q;
        // In IDLE the incoming address is presented so dm reads are ready early.
        dm_add    = (state_q == ST_IDLE) ? 32'(req_addr[AW-1:2]) : 32'(addr_q[AW-1:2]);
        dm_data_in = merge_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            op_q    <= OP_B;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        op_q    <= req_op;
                        wdata_q <= req_wdata;
                        // Full-word stores skip the read; sub-word stores
                        // overwrite this in RMW_RD.
                        merge_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_err;
                    end
                end
                ST_LOAD:   rdata_q <= load_val;
                ST_RMW_RD: merge_q <= store_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] dm_add;
    logic [31:0] dm_data_in;
    logic        dm_wen;
    logic [31:0] dm_data_out;

    int errors = 0;
    int checks = 0;

    // clock / reset
    always #5 clk = ~clk;

    lsu #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_add(dm_add), .dm_data_in(dm_data_in), .dm_wen(dm_wen), .dm_data_out(dm_data_out)
    );

    // data memory: combinational read, registered write; also a preload path
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;
    int          wen_cnt = 0;
    logic [31:0] last_wadd = 32'h0;

    assign dm_data_out = mem[dm_add[5:0]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (dm_wen) begin
            mem[dm_add[5:0]] <= dm_data_in;
            wen_cnt   <= wen_cnt + 1;
            last_wadd <= dm_add;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: byte-lane arithmetic on a word array
    function automatic logic model_err(input logic we, input logic [2:0] op, input logic [31:0] a);
        if (op == B)  return 1'b0;
        if (op == H)  return a[0];
        if (op == W)  return a[1:0] != 0;
        if (op == BU) return we;
        if (op == HU) return we || a[0];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] op, input int off);
        logic [31:0] v;
        v = word >> (8 * off);
        if (op == B || op == BU) begin
            v = v & 32'hFF;
            if (op == B && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (op == H || op == HU) begin
            v = v & 32'hFFFF;
            if (op == H && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] op,
                                                input int off, input logic [31:0] wd);
        logic [31:0] mask;
        if (op == W) return wd;
        mask = ((op == B) ? 32'hFF : 32'hFFFF) << (8 * off);
        return (word & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    // driver tasks
    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx[5:0]; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd);
        int          w, off, lat, exp_lat, wen0;
        logic        err, busy_ok;
        logic [31:0] exp_rd;
        w   = int'(addr[7:2]);
        off = int'(addr[1:0]);
        err = model_err(we, op, addr);
        exp_rd  = (err || we) ? 32'h0 : model_load(ref_mem[w], op, off);
        exp_lat = err ? 1 : (!we || op == W) ? 2 : 3;
        if (!err && we) ref_mem[w] = model_store(ref_mem[w], op, off, wd);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        wen0 = wen_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = $urandom;  // stray changes after accept must not matter
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            if (rsp_valid === 1'b1) break;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy"}, {31'h0, busy_ok}, 32'h1);
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
        check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, err});
        check({tag, ".wen_count"}, wen_cnt - wen0, (!err && we) ? 1 : 0);
        if (!err && we) check({tag, ".wen_addr"}, last_wadd, w);
        check({tag, ".mem"}, mem[w], ref_mem[w]);
    endtask

    initial begin
        // reset state
        req_addr = 32'h54;
        #2;
        check("rst.ready", {31'h0, req_ready}, 32'h1);
        check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst.rdata", rsp_rdata, 32'h0);
        check("rst.err", {31'h0, rsp_err}, 32'h0);
        check("rst.wen", {31'h0, dm_wen}, 32'h0);
        check("rst.data_in", dm_data_in, 32'h0);
        check("rst.dm_add", dm_add, 32'h15);
        #20;
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // directed steps
        preload(5, 32'h8899AABB);
        do_req("lb", 1'b0, B, 32'h16, 32'h0);
        check("lb.value", rsp_rdata, 32'hFFFFFF99);
        do_req("lbu", 1'b0, BU, 32'h16, 32'h0);
        check("lbu.value", rsp_rdata, 32'h00000099);
        do_req("sw", 1'b1, W, 32'h20, 32'h12345678);
        check("sw.add", last_wadd, 32'h8);
        do_req("lw", 1'b0, W, 32'h20, 32'h0);
        check("lw.value", rsp_rdata, 32'h12345678);
        preload(3, 32'hAABBCCDD);
        do_req("sh", 1'b1, H, 32'h0E, 32'h0000BEEF);
        check("sh.mem", mem[3], 32'hBEEFCCDD);
        do_req("lw_mis", 1'b0, W, 32'h21, 32'h0);
        do_req("sh_mis", 1'b1, H, 32'h03, 32'hFFFF);
        do_req("ld_op3", 1'b0, 3'b011, 32'h10, 32'h0);
        do_req("st_op4", 1'b1, 3'b100, 32'h10, 32'hAB);
        do_req("lh_hi", 1'b0, H, 32'h0E, 32'h0);
        do_req("lhu_hi", 1'b0, HU, 32'h0E, 32'h0);
        do_req("sb3", 1'b1, B, 32'h07, 32'hFFFFFF5A);

        // reset during RMW_RD of an SB: the write must never happen
        begin
            int wen0;
            logic [31:0] keep;
            keep = mem[9];
            wen0 = wen_cnt;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_op = B; req_addr = 32'h25; req_wdata = 32'h77;
            @(posedge clk);
            #1 req_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("arst.ready", {31'h0, req_ready}, 32'h1);
            check("arst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
            check("arst.wen", {31'h0, dm_wen}, 32'h0);
            check("arst.data_in", dm_data_in, 32'h0);
            check("arst.dm_add", dm_add, 32'h9);
            repeat (3) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            check("arst.no_write", wen_cnt - wen0, 0);
            check("arst.mem", mem[9], keep);
            check("arst.ready_after", {31'h0, req_ready}, 32'h1);
        end
        do_req("lw_after_rst", 1'b0, W, 32'h24, 32'h0);

        // randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [2:0]  op;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            op = (i % 8 == 7) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
            a  = 32'($urandom_range(0, 255));
            do_req("rand", we, op, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
